// File: rtl/me_pkg.sv
// Shared types and sizing for the motion-estimation pixel server.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_CPR,
    LOAD_SPR,
    SERVE
  } srv_state_t;

  typedef logic [7:0] pixel_t;

  localparam int unsigned MACRO_DIM_DEF  = 4;
  localparam int unsigned SEARCH_DIM_DEF = 16;
  localparam int unsigned CPR_BYTES      = MACRO_DIM_DEF * MACRO_DIM_DEF;
  localparam int unsigned SPR_BYTES      = SEARCH_DIM_DEF * SEARCH_DIM_DEF;
  localparam int unsigned CNT_W          = $clog2(SPR_BYTES) + 1;

  // Load counter width for an arbitrary search-window edge.
  function automatic int unsigned cnt_width(input int unsigned search_dim);
    return $clog2(search_dim * search_dim) + 1;
  endfunction

endpackage

// File: rtl/me_row_slicer.sv
// Combinational extraction of a MACRO_DIM+1 pixel window from one
// search-window row starting at column amt; columns past the row end read 0.
module me_row_slicer
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_DIM = SEARCH_DIM_DEF
) (
  input  pixel_t [SEARCH_DIM-1:0] row,
  input  logic   [5:0]            amt,
  output pixel_t [MACRO_DIM:0]    lanes
);

  localparam int unsigned SW  = $clog2(SEARCH_DIM);
  localparam logic [6:0]  SD7 = 7'(SEARCH_DIM);

  logic [6:0] col;

  // Per-lane column select with zero fill beyond the row end (no wrap).
  always_comb begin
    lanes = '0;
    col   = '0;
    for (int unsigned k = 0; k <= MACRO_DIM; k++) begin
      col = {1'b0, amt} + 7'(k);
      if (col < SD7) lanes[k] = row[col[SW-1:0]];
    end
  end

endmodule

// File: rtl/me_pixel_server.sv
// Pixel-supply responder for the ME engine: byte-serial fill of one current
// macroblock and one search window, then 1-cycle-latency row reads.
// Optional: define ME_SRV_RANGE_CHK_EN to add the rd_oor out-of-range flag.
module me_pixel_server
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_DIM = SEARCH_DIM_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    wr_valid,
  input  pixel_t                  wr_data,
  output logic                    wr_ready,
  output logic                    loaded,
  input  logic                    en_ram,
  input  logic   [5:0]            addr,
  input  logic   [5:0]            amt,
  output pixel_t [MACRO_DIM:0]    pixel_spr_out,
  output pixel_t [MACRO_DIM-1:0]  pixel_cpr_out,
  output logic                    rd_valid
`ifdef ME_SRV_RANGE_CHK_EN
  ,
  output logic                    rd_oor
`endif
);

  localparam int unsigned MW = $clog2(MACRO_DIM);
  localparam int unsigned SW = $clog2(SEARCH_DIM);
  localparam int unsigned CW = cnt_width(SEARCH_DIM);
  localparam logic [CW-1:0] CPR_LAST = CW'(MACRO_DIM * MACRO_DIM - 1);
  localparam logic [CW-1:0] SPR_LAST = CW'(SEARCH_DIM * SEARCH_DIM - 1);
  localparam logic [6:0]    SD7      = 7'(SEARCH_DIM);

  srv_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  pixel_t [MACRO_DIM-1:0]  cpr_mem [MACRO_DIM];
  pixel_t [SEARCH_DIM-1:0] spr_mem [SEARCH_DIM];

  logic                    wr_take;
  logic                    rd_hit;
  logic                    addr_in;
  pixel_t [SEARCH_DIM-1:0] spr_row;
  pixel_t [MACRO_DIM:0]    spr_slice;

  // A byte presented together with load_start is discarded: the fill restarts.
  assign wr_take = wr_valid && !load_start;
  assign rd_hit  = en_ram && (state == SERVE);
  assign addr_in = ({1'b0, addr} < SD7);
  assign spr_row = addr_in ? spr_mem[addr[SW-1:0]] : '0;

  // State and load counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, counter and load-port status.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_ready = 1'b0;
    loaded   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx = LOAD_CPR;
          cnt_nx   = '0;
        end
      end
      LOAD_CPR: begin
        wr_ready = 1'b1;
        if (load_start) begin
          cnt_nx = '0;
        end else if (wr_valid) begin
          if (cnt == CPR_LAST) begin
            state_nx = LOAD_SPR;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      LOAD_SPR: begin
        wr_ready = 1'b1;
        if (load_start) begin
          state_nx = LOAD_CPR;
          cnt_nx   = '0;
        end else if (wr_valid) begin
          if (cnt == SPR_LAST) begin
            state_nx = SERVE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      SERVE: begin
        loaded = 1'b1;
        if (load_start) begin
          state_nx = LOAD_CPR;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Raster-order storage writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_take) begin
      if (state == LOAD_CPR)
        cpr_mem[cnt[2*MW-1:MW]][cnt[MW-1:0]] <= wr_data;
      else if (state == LOAD_SPR)
        spr_mem[cnt[2*SW-1:SW]][cnt[SW-1:0]] <= wr_data;
    end
  end

  me_row_slicer #(
    .MACRO_DIM  (MACRO_DIM),
    .SEARCH_DIM (SEARCH_DIM)
  ) u_slicer (
    .row   (spr_row),
    .amt   (amt),
    .lanes (spr_slice)
  );

  // Read result registers; pixel outputs hold between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid      <= 1'b0;
      pixel_spr_out <= '0;
      pixel_cpr_out <= '0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) begin
        pixel_spr_out <= spr_slice;
        pixel_cpr_out <= cpr_mem[addr[MW-1:0]];
      end
    end
  end

`ifdef ME_SRV_RANGE_CHK_EN
  // Out-of-range flag, aligned with rd_valid; also pulses on strobes outside SERVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_oor <= 1'b0;
    end else begin
      rd_oor <= en_ram && ((state != SERVE) || !addr_in ||
                           (({1'b0, amt} + 7'(MACRO_DIM)) >= SD7));
    end
  end
`endif

endmodule

// File: doc/me_pixel_server.md
Name: me_pixel_server

Overview:
- Pixel-supply responder for the motion-estimation engine. It answers the engine's en_ram/addr/amt read requests with one search-region row slice and one current-macroblock row.
- Holds one current macroblock and one search window in internal storage. Both are filled byte-serially from the frame-buffer side through a valid/ready load port.
- Sits between the frame-buffer fetch logic and the ME core; one instance per ME core.

Parameters:
- MACRO_DIM, 4, macroblock edge in pixels; power of two, 2..8.
- SEARCH_DIM, 16, search-window edge in pixels; power of two, at most 32, greater than MACRO_DIM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse; begins a new fill (current block, then search window)
- wr_valid  in  1  load byte valid
- wr_data  in  8  load pixel, raster order
- wr_ready  out  1  load byte accepted when wr_valid && wr_ready
- loaded  out  1  storage complete, read service active
- en_ram  in  1  read request strobe from ME engine
- addr  in  6  search-window row index
- amt  in  6  horizontal column offset into the search row
- pixel_spr_out  out  8 x (MACRO_DIM+1)  search pixels [0:MACRO_DIM]
- pixel_cpr_out  out  8 x MACRO_DIM  current-block pixels [0:MACRO_DIM-1]
- rd_valid  out  1  read data valid, one cycle after an accepted en_ram

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: FSM = IDLE; wr_ready = 0, loaded = 0, rd_valid = 0; all pixel outputs = 0; load counter = 0. Storage contents are not reset and are don't-care.
- FSM states: IDLE, LOAD_CPR, LOAD_SPR, SERVE.
- IDLE:
  - load_start → LOAD_CPR, counter cleared.
- LOAD_CPR:
  - wr_ready = 1.
  - Each handshake writes cpr[cnt / MACRO_DIM][cnt % MACRO_DIM].
  - After MACRO_DIM² bytes → LOAD_SPR, counter cleared.
- LOAD_SPR:
  - wr_ready = 1.
  - Each handshake writes spr[row][col] in raster order.
  - After SEARCH_DIM² bytes → SERVE, loaded = 1 from the next cycle.
- SERVE:
  - wr_ready = 0.
  - load_start → LOAD_CPR, loaded = 0 next cycle; any in-flight read still completes.
- Load-port rules:
  - wr_valid outside the LOAD states is ignored.
  - load_start during a LOAD state restarts the fill from LOAD_CPR with the counter at 0.
- Read path (SERVE only), fixed latency 1 cycle:
  - en_ram sampled at edge N → rd_valid = 1 during cycle N+1, for exactly one cycle per strobe.
  - pixel_spr_out[k] = spr[addr][amt+k] for k = 0..MACRO_DIM.
  - pixel_cpr_out[k] = cpr[addr mod MACRO_DIM][k].
  - Back-to-back en_ram is supported, one result per cycle.
  - Outputs hold their last value when rd_valid = 0.
- Boundaries:
  - Column amt+k ≥ SEARCH_DIM returns 0 for that lane; there is no wrap.
  - addr ≥ SEARCH_DIM returns all spr lanes = 0; cpr lanes still use addr mod MACRO_DIM.
  - en_ram outside SERVE: rd_valid stays 0 and outputs are unchanged.
  - Column arithmetic is 7-bit unsigned, so amt + MACRO_DIM cannot overflow.
  - Reset mid-load or mid-read: immediate return to IDLE and reset values; the fill must be repeated.

Optional Feature:
- Macro ME_SRV_RANGE_CHK_EN.
- Defined:
  - Extra output rd_oor (1 bit), aligned with rd_valid.
  - rd_oor = 1 when addr ≥ SEARCH_DIM or amt+MACRO_DIM ≥ SEARCH_DIM for that read; reset value 0.
  - rd_oor also pulses for one cycle when en_ram arrives outside SERVE.
- Undefined: the port is absent; zero-fill behaviour is unchanged.

Decomposition:
- Package me_pkg holds:
  - state enum typedef srv_state_t {IDLE, LOAD_CPR, LOAD_SPR, SERVE};
  - pixel_t (8-bit) typedef;
  - localparams CPR_BYTES = MACRO_DIM², SPR_BYTES = SEARCH_DIM², CNT_W = $clog2(SPR_BYTES)+1.
- One sub-module, me_row_slicer: combinational extraction of a MACRO_DIM+1 window from a SEARCH_DIM-pixel row at offset amt, with zero fill. The top module holds the FSM, storage and output registers.

Test Plan:
- Reset behaviour: reset asserted mid-LOAD_SPR (after 100 bytes) → wr_ready = 0, loaded = 0, rd_valid = 0 immediately; a following full fill succeeds.
- Basic read: fill cpr[i] = i and spr[r][c] = 16r + c (defaults); en_ram with addr = 3, amt = 5 → next cycle rd_valid = 1, spr lanes = 53,54,55,56,57, cpr lanes = 12,13,14,15.
- Edge zero fill: addr = 15, amt = 13 → spr lanes = 253,254,255,0,0; with ME_SRV_RANGE_CHK_EN, rd_oor = 1.
- Back-to-back reads: en_ram held 16 cycles, addr = 0..15, amt = 0 → 16 consecutive rd_valid cycles; cpr row cycles 0,1,2,3,0,…
- Load backpressure and reload: wr_valid toggled randomly → exactly 16 + 256 bytes accepted, then loaded = 1; load_start in SERVE → loaded = 0 next cycle, and en_ram then yields no rd_valid until the refill completes.
- Read before load: en_ram while in IDLE → rd_valid stays 0 and outputs remain 0.
